div_iter: RTL

Multi-cycle radix-2 restoring integer divider for the EX stage. It serves the divide request that the ALU raises for DIV/DIVU: it latches the operands, stalls the pipeline while it iterates, and returns {remainder, quotient} for the HI/LO write. It computes one quotient bit per clock and supports signed and unsigned operation, pipeline flush and external hold.

---
 rtl/div_iter.sv | 107 ++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// 33-cycle stall for a normal divide, result packed as {remainder, quotient}.
module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        sign,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        hold,
  output logic        div_stall,
  output logic        done,
  output logic [63:0] result,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvsr;
  logic        neg_q;
  logic        neg_r;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic        nonneg;
  logic [31:0] rem_nx;
  logic [31:0] quo_nx;

  // Magnitudes are taken only for signed ops; DIVU operands pass through untouched.
  always_comb begin
    abs_a = (sign && a[31]) ? (32'd0 - a) : a;
    abs_b = (sign && b[31]) ? (32'd0 - b) : b;
  end

  // One restoring step: bit 32 of the 33-bit trial is the borrow.
  always_comb begin
    rem_sh = {rem, quo[31]};
    trial  = rem_sh - {1'b0, dvsr};
    nonneg = ~trial[32];
    rem_nx = nonneg ? trial[31:0] : rem_sh[31:0];
    quo_nx = {quo[30:0], nonneg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      dvsr   <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= 64'd0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            if (b == 32'd0) begin
              result <= {a, 32'hFFFF_FFFF};
              state  <= DONE;
            end else begin
              quo   <= abs_a;
              dvsr  <= abs_b;
              rem   <= 32'd0;
              cnt   <= 5'd0;
              neg_q <= sign & (a[31] ^ b[31]);
              neg_r <= sign & a[31];
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            result <= {neg_r ? (32'd0 - rem_nx) : rem_nx,
                       neg_q ? (32'd0 - quo_nx) : quo_nx};
            state  <= DONE;
          end
        end
        DONE: begin
          if (!hold) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_stall = valid & (state != DONE);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
